// File: rtl/sw_conditioner.sv
// sw_conditioner: synchronizes and debounces 12 slide switches and 2 push
// buttons for the shifter front end.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   sw[11:0]   raw slide switches (asynchronous)
//   btn[1:0]   raw push buttons (asynchronous)
//   sw_out     conditioned switches (debounced, or held copy under SW_HOLD_EN)
//   btn_out    debounced buttons
//   btn_rise   one-cycle pulse per debounced button 0->1 edge
//   sw_changed one-cycle pulse when any debounced switch bit changes
//
// Parameters:
//   TICK_DIV   clk cycles per debounce sample tick (>= 2)
//   DB_TICKS   consecutive disagreeing ticks needed to accept a new level (>= 1)
//
// Optional feature macro: SW_HOLD_EN -- sw_out shows a snapshot of the
// debounced switches captured on each btn[1] press instead of the live value.

module sw_conditioner #(
  parameter int unsigned TICK_DIV = 100000,
  parameter int unsigned DB_TICKS = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] sw,
  input  logic [1:0]  btn,
  output logic [11:0] sw_out,
  output logic [1:0]  btn_out,
  output logic [1:0]  btn_rise,
  output logic        sw_changed
);

  localparam int unsigned NSW = 12;
  localparam int unsigned NIN = 14;
  localparam int unsigned PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CW  = (DB_TICKS > 0) ? $clog2(DB_TICKS + 1) : 1;

  logic [NIN-1:0] r_sync1;
  logic [NIN-1:0] r_sync2;
  logic [NIN-1:0] r_db;
  logic [NIN-1:0] w_db_next;
  logic [PW-1:0]  r_pre;
  logic           w_tick;
  logic [CW-1:0]  r_cnt      [NIN];
  logic [CW-1:0]  w_cnt_next [NIN];
  logic [1:0]     r_btn_rise;
  logic           r_sw_changed;

  // Two-flop synchronizer; bits 11:0 are switches, 13:12 are buttons.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {btn, sw};
      r_sync2 <= r_sync1;
    end
  end

  // Shared sample-tick prescaler.
  assign w_tick = (r_pre == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end

  // Per-input stability counter: any agreeing cycle restarts the count, so a
  // glitch shorter than a tick period never accumulates.
  always_comb begin
    w_db_next = r_db;
    for (int i = 0; i < NIN; i++) begin
      w_cnt_next[i] = r_cnt[i];
      if (r_sync2[i] == r_db[i]) begin
        w_cnt_next[i] = '0;
      end else if (w_tick) begin
        if (r_cnt[i] == CW'(DB_TICKS - 1)) begin
          w_db_next[i]  = r_sync2[i];
          w_cnt_next[i] = '0;
        end else begin
          w_cnt_next[i] = r_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db <= '0;
      for (int i = 0; i < NIN; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_db <= w_db_next;
      for (int i = 0; i < NIN; i++) begin
        r_cnt[i] <= w_cnt_next[i];
      end
    end
  end

  // Edge pulses are registered alongside the db update so they coincide with
  // the first cycle the new debounced level is visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_rise   <= '0;
      r_sw_changed <= 1'b0;
    end else begin
      r_btn_rise   <= w_db_next[NIN-1:NSW] & ~r_db[NIN-1:NSW];
      r_sw_changed <= |(w_db_next[NSW-1:0] ^ r_db[NSW-1:0]);
    end
  end

  assign btn_out    = r_db[NIN-1:NSW];
  assign btn_rise   = r_btn_rise;
  assign sw_changed = r_sw_changed;

`ifdef SW_HOLD_EN
  logic [NSW-1:0] r_held;

  // Snapshot switches on a btn[1] press; reads the current db, so a switch
  // edge landing in the same cycle is captured with its pre-change value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_held <= '0;
    end else if (r_btn_rise[1]) begin
      r_held <= r_db[NSW-1:0];
    end
  end

  assign sw_out = r_held;
`else
  assign sw_out = r_db[NSW-1:0];
`endif

endmodule

// File: tb/tb_sw_conditioner.sv
// Self-checking bench for sw_conditioner (TICK_DIV=4, DB_TICKS=3).
// A cycle-level reference model runs continuously and is compared against the
// DUT on every falling edge; directed sequences and a vector table add checks
// for latency, glitch rejection, pulse counts, reset and the hold feature.

module tb_sw_conditioner;

  localparam int TICK_DIV = 4;
  localparam int DB_TICKS = 3;

  logic        clk;
  logic        rst_n;
  logic [11:0] sw;
  logic [1:0]  btn;
  logic [11:0] sw_out;
  logic [1:0]  btn_out;
  logic [1:0]  btn_rise;
  logic        sw_changed;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  sw_conditioner #(.TICK_DIV(TICK_DIV), .DB_TICKS(DB_TICKS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw         (sw),
    .btn        (btn),
    .sw_out     (sw_out),
    .btn_out    (btn_out),
    .btn_rise   (btn_rise),
    .sw_changed (sw_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Each raw input is seen two edges late; a new level is accepted once it
  // has disagreed with the accepted level across DB_TICKS consecutive ticks
  // with no agreeing cycle in between. Ticks fall every TICK_DIV-th cycle
  // counted from reset release.
  logic [13:0] m_s1, m_s2, m_db;
  logic [1:0]  m_rise;
  logic        m_chg;
  logic [11:0] m_held;
  int          m_cyc;
  int          m_run [14];
  logic [13:0] t_db;
  int          t_run [14];
  bit          t_tick;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1   <= '0;
      m_s2   <= '0;
      m_db   <= '0;
      m_rise <= '0;
      m_chg  <= 1'b0;
      m_held <= '0;
      m_cyc  <= 0;
      for (int i = 0; i < 14; i++) m_run[i] <= 0;
    end else begin
      t_tick = ((m_cyc % TICK_DIV) == TICK_DIV - 1);
      t_db   = m_db;
      for (int i = 0; i < 14; i++) begin
        if (m_s2[i] == m_db[i]) t_run[i] = 0;
        else if (t_tick) begin
          if (m_run[i] + 1 >= DB_TICKS) begin
            t_db[i]  = m_s2[i];
            t_run[i] = 0;
          end else t_run[i] = m_run[i] + 1;
        end else t_run[i] = m_run[i];
      end
      m_s1   <= {btn, sw};
      m_s2   <= m_s1;
      m_db   <= t_db;
      for (int i = 0; i < 14; i++) m_run[i] <= t_run[i];
      m_rise <= t_db[13:12] & ~m_db[13:12];
      m_chg  <= |(t_db[11:0] ^ m_db[11:0]);
      if (m_rise[1]) m_held <= m_db[11:0];
      m_cyc  <= m_cyc + 1;
    end
  end

  function automatic logic [16:0] model_out();
`ifdef SW_HOLD_EN
    return {m_held, m_db[13:12], m_rise, m_chg};
`else
    return {m_db[11:0], m_db[13:12], m_rise, m_chg};
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  // Continuous model comparison, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) chk("model", 32'({sw_out, btn_out, btn_rise, sw_changed}), 32'(model_out()));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [11:0] sw;
    logic [1:0]  btn;
    logic [11:0] exp_plain;
    logic [11:0] exp_hold;
    logic [1:0]  exp_btn;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int k, first, pulses;
    logic [11:0] exp_sw;

    tbl[0] = '{12'hA5C, 2'b00, 12'hA5C, 12'h000, 2'b00};
    tbl[1] = '{12'hA5C, 2'b10, 12'hA5C, 12'hA5C, 2'b10};
    tbl[2] = '{12'h000, 2'b10, 12'h000, 12'hA5C, 2'b10};
    tbl[3] = '{12'h000, 2'b00, 12'h000, 12'hA5C, 2'b00};
    tbl[4] = '{12'hFFF, 2'b11, 12'hFFF, 12'hFFF, 2'b11};
    tbl[5] = '{12'h123, 2'b01, 12'h123, 12'hFFF, 2'b01};
    tbl[6] = '{12'h123, 2'b11, 12'h123, 12'h123, 2'b11};

    sw = '0; btn = '0; rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    chk("reset_outputs", 32'({sw_out, btn_out, btn_rise, sw_changed}), 32'h0);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (5) step();
    k = $urandom_range(0, 3);
    repeat (k) step();

    // Clean switch step: latency window and a single change pulse.
    sw[3] = 1'b1;
    first = -1; pulses = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (sw_changed) begin
        pulses++;
        if (first < 0) first = c;
      end
    end
    chk("sw3_latency_ok", 32'((first >= 11) && (first <= 15)), 32'h1);
    chk("sw3_pulses", 32'(pulses), 32'd1);
`ifndef SW_HOLD_EN
    chk("sw3_out", 32'(sw_out[3]), 32'h1);
`endif

    // Short glitch on sw[0] is rejected.
    step();
    sw[0] = 1'b1;
    repeat (3) step();
    sw[0] = 1'b0;
    pulses = 0; k = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (sw_changed) pulses++;
      if (sw_out[0]) k++;
    end
    chk("glitch_pulses", 32'(pulses), 32'd0);
    chk("glitch_sw0_high_cycles", 32'(k), 32'd0);

    // Button press/release: one rise pulse, none on release.
    step();
    btn[0] = 1'b1;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (btn_rise[0]) pulses++;
    end
    chk("btn0_rise_press", 32'(pulses), 32'd1);
    chk("btn0_out_high", 32'(btn_out[0]), 32'h1);
    step();
    btn[0] = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (btn_rise[0]) pulses++;
    end
    chk("btn0_rise_total", 32'(pulses), 32'd1);
    chk("btn0_out_low", 32'(btn_out[0]), 32'h0);

    // Reset in the middle of a debounce, input held through reset.
    sw[5] = 1'b1;
    k = 0;
    while (m_run[5] != 2 && k < 40) begin
      step();
      k++;
    end
    chk("mid_debounce_reached", 32'(k < 40), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_outputs", 32'({sw_out, btn_out, btn_rise, sw_changed}), 32'h0);
    step();
    rst_n = 1'b1;
    first = -1; pulses = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (sw_changed) begin
        pulses++;
        if (first < 0) first = c;
      end
    end
    chk("post_reset_latency_ok", 32'((first >= 11) && (first <= 15)), 32'h1);
    chk("post_reset_pulses", 32'(pulses), 32'd1);
`ifndef SW_HOLD_EN
    chk("post_reset_sw_out", 32'(sw_out), 32'h028);
`endif

    // Vector table: settle each input pattern, then check outputs.
    for (int v = 0; v < 7; v++) begin
      step();
      sw  = tbl[v].sw;
      btn = tbl[v].btn;
      repeat (20) step();
`ifdef SW_HOLD_EN
      exp_sw = tbl[v].exp_hold;
`else
      exp_sw = tbl[v].exp_plain;
`endif
      chk($sformatf("tbl%0d_sw_out", v), 32'(sw_out), 32'(exp_sw));
      chk($sformatf("tbl%0d_btn_out", v), 32'(btn_out), 32'(tbl[v].exp_btn));
    end

    // Randomized segments against the reference model.
    for (int s = 0; s < 250; s++) begin
      if ($urandom_range(0, 3) == 0) begin
        sw  = 12'($urandom);
        btn = 2'($urandom);
      end else begin
        sw[$urandom_range(0, 11)] = ~sw[$urandom_range(0, 11)];
        if ($urandom_range(0, 1) == 1) btn = 2'($urandom);
      end
      repeat ($urandom_range(1, 24)) step();
    end

    repeat (5) step();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
